seg_scan_ctrl: RTL

- Upstream time-multiplexing stage for the 4-digit seven-segment decoder.
- Holds a 4-digit BCD value loaded over a valid/ready handshake, double-buffered so a frame never tears.
- Scans digits 0..3 round-robin, presenting one digit at a time as {disp_sel, disp_val}, which concatenates directly onto the decoder's 8-bit input (sel high nibble, value low nibble).
- Inserts a blanking interval between digits to suppress ghosting.

---
 rtl/seg_scan_ctrl_if.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
//   Load-side bus for seg_scan_ctrl: a valid/ready transfer of four BCD
//   digits plus the one-cycle error pulse returned for a rejected value.
//
//   load_valid  producer -> ctrl   load_data is valid
//   load_ready  ctrl -> producer   shadow register free, transfer may occur
//   load_data   producer -> ctrl   [3:0] digit 0 (rightmost) .. [15:12] digit 3
//   load_err    ctrl -> producer   accepted value contained a nibble > 9
//
//   master: the producer of display values
//   slave : seg_scan_ctrl

interface seg_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        load_err;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  load_err
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output load_err
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexing front end for a 4-digit seven-segment decoder.
//   A 4-digit BCD value is loaded into a shadow register and copied into
//   the active register only at a frame boundary (end of digit 3's slot),
//   so a frame never shows a mix of old and new digits. Digits 0..3 are
//   scanned round-robin; each slot starts with BLANK_CNT dark clocks to
//   suppress ghosting. {disp_sel, disp_val} feeds the decoder directly.
//
//   Optional feature: define LZ_BLANK_EN for leading-zero blanking of
//   digits 3..1 (digit 0 is always shown when masked in).
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active low
//   ld          load bus (seg_scan_ctrl_if.slave)
//   digit_mask  per-digit enable, 1 = digit may light
//   disp_sel    one-hot active-high digit enable, 0 = all dark
//   disp_val    BCD value of the selected digit (holds while dark)
//   frame_done  one-cycle pulse after the last edge of digit 3's slot
//
// Parameters
//   DIV_CNT     clocks per digit slot (>= 2)
//   BLANK_CNT   dark clocks at the start of each slot (< DIV_CNT)
//
// state | meaning
// ------+----------------------------------------------------------
// BLANK | slot counter < BLANK_CNT, all digits dark
// ON    | slot counter >= BLANK_CNT, selected digit may light

module seg_scan_ctrl #(
    parameter int DIV_CNT   = 100000,
    parameter int BLANK_CNT = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_ctrl_if.slave      ld,
    input  logic [3:0]          digit_mask,
    output logic [3:0]          disp_sel,
    output logic [3:0]          disp_val,
    output logic                frame_done
);

    localparam int CW = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV_CNT - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CNT);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [3:0][3:0] active;
    logic [3:0][3:0] shadow;
    logic            pending;

    logic [CW-1:0]   cnt_nxt;
    logic [1:0]      idx_nxt;
    logic            cnt_last;
    logic            boundary;
    logic            load_fire;
    logic            load_bad;
    logic [3:0]      lz_dark;
    logic            lit_en;

    always_comb begin
        cnt_last  = (cnt == CNT_LAST);
        cnt_nxt   = cnt_last ? '0 : cnt + 1'b1;
        idx_nxt   = cnt_last ? idx + 2'd1 : idx;
        boundary  = cnt_last && (idx == 2'd3);
        load_fire = ld.load_valid && ld.load_ready;
        load_bad  = (ld.load_data[3:0]   > 4'd9) || (ld.load_data[7:4]   > 4'd9) ||
                    (ld.load_data[11:8]  > 4'd9) || (ld.load_data[15:12] > 4'd9);
    end

    // A digit is a leading zero when it and every higher digit are zero.
    always_comb begin
        lz_dark = 4'b0000;
`ifdef LZ_BLANK_EN
        lz_dark[3] = (active[3] == 4'd0);
        lz_dark[2] = lz_dark[3] && (active[2] == 4'd0);
        lz_dark[1] = lz_dark[2] && (active[1] == 4'd0);
`endif
    end

    always_comb begin
        lit_en = (state == S_ON) && digit_mask[idx] && !lz_dark[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_BLANK;
            cnt           <= '0;
            idx           <= 2'd0;
            active        <= '0;
            shadow        <= '0;
            pending       <= 1'b0;
            disp_sel      <= 4'b0000;
            disp_val      <= 4'd0;
            frame_done    <= 1'b0;
            ld.load_ready <= 1'b1;
            ld.load_err   <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;

            // State tracks the counter value it will hold after this edge,
            // so state and cnt always describe the same clock.
            if (cnt_nxt < BLANK_LIM) begin
                state <= S_BLANK;
            end else begin
                state <= S_ON;
            end

            // Outputs reflect the pre-edge counter/state: one clock behind.
            if (lit_en) begin
                disp_sel <= 4'b0001 << idx;
                disp_val <= active[idx];
            end else begin
                disp_sel <= 4'b0000;
            end

            frame_done  <= boundary;
            ld.load_err <= load_fire && load_bad;

            // load_ready is only high while nothing is pending, so a load
            // accepted on the boundary edge never collides with the copy:
            // the copy sees the old pending flag and the new data waits.
            if (boundary && pending) begin
                active        <= shadow;
                pending       <= 1'b0;
                ld.load_ready <= 1'b1;
            end

            if (load_fire && !load_bad) begin
                shadow        <= ld.load_data;
                pending       <= 1'b1;
                ld.load_ready <= 1'b0;
            end
        end
    end

endmodule
